// File: rtl/text_renderer.sv
// Character-cell text renderer: fetches glyph indices, reads char ROM rows and
// serialises them as a pixel stream. Optional cursor inversion via TEXT_CURSOR_EN.
module text_renderer #(
    parameter int WIDTH   = 8,
    parameter int COLS    = 80,
    parameter int BITS    = 4,
    parameter int COLBITS = 7,
    parameter int ROWBITS = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       linestart,
    input  logic [ROWBITS+2:0]         line,
    output logic                       tren,
    output logic [ROWBITS+COLBITS-1:0] taddr,
    input  logic [BITS-1:0]            tdata,
    output logic                       creaden,
    output logic [BITS-1:0]            csel,
    output logic [2:0]                 cy,
    input  logic [WIDTH-1:0]           crow,
    output logic                       pixel,
    output logic                       pixvalid,
    output logic                       busy,
    output logic                       lineend
`ifdef TEXT_CURSOR_EN
    ,
    input  logic                       curon,
    input  logic [COLBITS-1:0]         curcol,
    input  logic [ROWBITS-1:0]         currow
`endif
);

    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0]    P_FETCH = PW'(WIDTH - 4);
    localparam logic [PW-1:0]    P_LAST  = PW'(WIDTH - 1);
    localparam logic [PW-1:0]    P_ONE   = PW'(1);
    localparam logic [COLBITS:0] COL_END = (COLBITS + 1)'(COLS);
    localparam logic [COLBITS:0] COL_ONE = (COLBITS + 1)'(1);

    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

    state_t               state_q, state_d;
    logic [ROWBITS-1:0]   row_q, row_d;
    logic [2:0]           cy_q, cy_d;
    logic [COLBITS:0]     col_q, col_d;
    logic                 creaden_q, creaden_d;
    logic                 rd2_q, rd2_d;
    logic                 rd3_q, rd3_d;
    logic                 cur1_q, cur1_d;
    logic                 cur2_q, cur2_d;
    logic                 cur3_q, cur3_d;
    logic [WIDTH-1:0]     sh_q, sh_d;
    logic [PW-1:0]        pcnt_q, pcnt_d;
    logic                 lineend_q, lineend_d;
    logic                 fetch;
    logic                 cur_hit;

    always_comb begin
`ifdef TEXT_CURSOR_EN
        cur_hit = curon && (row_q == currow) && (col_q[COLBITS-1:0] == curcol);
`else
        cur_hit = 1'b0;
`endif
        // First fetch in the cycle after linestart; later ones timed so each
        // row lands exactly as the previous glyph's last pixel leaves.
        fetch = 1'b0;
        if (state_q == PRIME && col_q == '0)
            fetch = 1'b1;
        if (state_q == RUN && pcnt_q == P_FETCH && col_q != COL_END)
            fetch = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        cy_d      = cy_q;
        col_d     = col_q;
        creaden_d = creaden_q;
        rd2_d     = rd2_q;
        rd3_d     = rd3_q;
        cur1_d    = cur1_q;
        cur2_d    = cur2_q;
        cur3_d    = cur3_q;
        sh_d      = sh_q;
        pcnt_d    = pcnt_q;
        lineend_d = 1'b0;
        if (linestart) begin
            // Also serves as abort: everything in flight is dropped.
            state_d   = PRIME;
            row_d     = line[ROWBITS+2:3];
            cy_d      = line[2:0];
            col_d     = '0;
            creaden_d = 1'b0;
            rd2_d     = 1'b0;
            rd3_d     = 1'b0;
            cur1_d    = 1'b0;
            cur2_d    = 1'b0;
            cur3_d    = 1'b0;
            sh_d      = '0;
            pcnt_d    = '0;
        end else begin
            if (fetch)
                col_d = col_q + COL_ONE;
            creaden_d = fetch;
            rd2_d     = creaden_q;
            rd3_d     = rd2_q;
            cur1_d    = fetch && cur_hit;
            cur2_d    = cur1_q;
            cur3_d    = cur2_q;
            case (state_q)
                PRIME: begin
                    if (rd3_q) begin
                        sh_d    = crow ^ {WIDTH{cur3_q}};
                        pcnt_d  = '0;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pcnt_q == P_LAST) begin
                        pcnt_d = '0;
                        if (rd3_q) begin
                            sh_d = crow ^ {WIDTH{cur3_q}};
                        end else begin
                            sh_d      = '0;
                            state_d   = IDLE;
                            lineend_d = 1'b1;
                        end
                    end else begin
                        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
                        pcnt_d = pcnt_q + P_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            row_q     <= '0;
            cy_q      <= '0;
            col_q     <= '0;
            creaden_q <= 1'b0;
            rd2_q     <= 1'b0;
            rd3_q     <= 1'b0;
            cur1_q    <= 1'b0;
            cur2_q    <= 1'b0;
            cur3_q    <= 1'b0;
            sh_q      <= '0;
            pcnt_q    <= '0;
            lineend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            cy_q      <= cy_d;
            col_q     <= col_d;
            creaden_q <= creaden_d;
            rd2_q     <= rd2_d;
            rd3_q     <= rd3_d;
            cur1_q    <= cur1_d;
            cur2_q    <= cur2_d;
            cur3_q    <= cur3_d;
            sh_q      <= sh_d;
            pcnt_q    <= pcnt_d;
            lineend_q <= lineend_d;
        end
    end

    assign tren     = fetch;
    assign taddr    = {row_q, col_q[COLBITS-1:0]};
    assign creaden  = creaden_q;
    assign csel     = tdata;
    assign cy       = cy_q;
    assign pixvalid = (state_q == RUN);
    assign pixel    = pixvalid & sh_q[WIDTH-1];
    assign busy     = (state_q != IDLE);
    assign lineend  = lineend_q;

endmodule

// File: tb/tb_text_renderer.sv
// Scoreboard bench for text_renderer: two instances (8x2 and 4x3 cells), a text
// buffer / char ROM model each, expected events queued at stimulus time.
module tb_text_renderer;

    typedef struct {int cyc; logic [1:0] code;} ev_t;
    typedef struct {int cyc; logic [11:0] addr; logic [2:0] cy;} fe_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- DUT A: WIDTH=8, COLS=2 ----------------
    logic        ls_a = 1'b0;
    logic [7:0]  line_a = '0;
    logic        tren_a, creaden_a, pixel_a, pixvalid_a, busy_a, lineend_a;
    logic [11:0] taddr_a;
    logic [3:0]  tdata_a = '0;
    logic [3:0]  csel_a;
    logic [2:0]  cy_a;
    logic [7:0]  crow_a, st1_a = '0, st2_a = '0;
`ifdef TEXT_CURSOR_EN
    logic        curon = 1'b0;
    logic [6:0]  curcol = '0;
    logic [4:0]  currow = '0;
`endif

    text_renderer #(.WIDTH(8), .COLS(2)) dut_a (
        .clk(clk), .rst(rst), .linestart(ls_a), .line(line_a),
        .tren(tren_a), .taddr(taddr_a), .tdata(tdata_a),
        .creaden(creaden_a), .csel(csel_a), .cy(cy_a), .crow(crow_a),
        .pixel(pixel_a), .pixvalid(pixvalid_a), .busy(busy_a), .lineend(lineend_a)
`ifdef TEXT_CURSOR_EN
        , .curon(curon), .curcol(curcol), .currow(currow)
`endif
    );

    function automatic logic [7:0] rom_a(input logic [3:0] g);
        case (g)
            4'd1:    return 8'hA5;
            4'd2:    return 8'h3C;
            default: return 8'h00;
        endcase
    endfunction

    // Column c of any row holds glyph c+1; ROM read latency is two cycles.
    always @(posedge clk) begin
        if (tren_a) tdata_a <= 4'(taddr_a[0]) + 4'd1;
        st1_a <= creaden_a ? rom_a(csel_a) : 8'h00;
        st2_a <= st1_a;
    end
    assign crow_a = st2_a;

    // ---------------- DUT B: WIDTH=4, COLS=3 ----------------
    logic        ls_b = 1'b0;
    logic [7:0]  line_b = '0;
    logic        tren_b, creaden_b, pixel_b, pixvalid_b, busy_b, lineend_b;
    logic [11:0] taddr_b;
    logic [3:0]  tdata_b = '0;
    logic [3:0]  csel_b;
    logic [2:0]  cy_b;
    logic [3:0]  crow_b, st1_b = '0, st2_b = '0;

    text_renderer #(.WIDTH(4), .COLS(3)) dut_b (
        .clk(clk), .rst(rst), .linestart(ls_b), .line(line_b),
        .tren(tren_b), .taddr(taddr_b), .tdata(tdata_b),
        .creaden(creaden_b), .csel(csel_b), .cy(cy_b), .crow(crow_b),
        .pixel(pixel_b), .pixvalid(pixvalid_b), .busy(busy_b), .lineend(lineend_b)
`ifdef TEXT_CURSOR_EN
        , .curon(1'b0), .curcol(7'd0), .currow(5'd0)
`endif
    );

    always @(posedge clk) begin
        if (tren_b) tdata_b <= 4'd1;
        st1_b <= creaden_b ? 4'hF : 4'h0;
        st2_b <= st1_b;
    end
    assign crow_b = st2_b;

    // ---------------- scoreboards ----------------
    ev_t evq_a[$];
    ev_t evq_b[$];
    fe_t fq_a[$];
    fe_t fq_b[$];

    ev_t        e_a, e_b;
    fe_t        f_a, f_b;
    logic [1:0] code_a, code_b;
    int         last_tren_a = -10, last_tren_b = -10;
    logic [2:0] exp_cy_a = '0, exp_cy_b = '0;

    always @(negedge clk) begin
        if (pixvalid_a || lineend_a) begin
            code_a = pixvalid_a ? (lineend_a ? 2'd3 : {1'b0, pixel_a}) : 2'd2;
            if (evq_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_spurious_out: got code %0d at cycle %0d, required no output", code_a, cyc);
            end else begin
                e_a = evq_a.pop_front();
                chk("a_out_cycle", cyc, e_a.cyc);
                chk("a_out_value", int'(code_a), int'(e_a.code));
            end
        end
        if (tren_a) begin
            if (fq_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_spurious_fetch: got taddr %0h at cycle %0d, required no fetch", taddr_a, cyc);
            end else begin
                f_a = fq_a.pop_front();
                chk("a_fetch_cycle", cyc, f_a.cyc);
                chk("a_taddr", int'(taddr_a), int'(f_a.addr));
                exp_cy_a = f_a.cy;
            end
            last_tren_a = cyc;
        end
        if (creaden_a) begin
            chk("a_creaden_lag", cyc, last_tren_a + 1);
            chk("a_cy", int'(cy_a), int'(exp_cy_a));
        end
    end

    always @(negedge clk) begin
        if (pixvalid_b || lineend_b) begin
            code_b = pixvalid_b ? (lineend_b ? 2'd3 : {1'b0, pixel_b}) : 2'd2;
            if (evq_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_spurious_out: got code %0d at cycle %0d, required no output", code_b, cyc);
            end else begin
                e_b = evq_b.pop_front();
                chk("b_out_cycle", cyc, e_b.cyc);
                chk("b_out_value", int'(code_b), int'(e_b.code));
            end
        end
        if (tren_b) begin
            if (fq_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_spurious_fetch: got taddr %0h at cycle %0d, required no fetch", taddr_b, cyc);
            end else begin
                f_b = fq_b.pop_front();
                chk("b_fetch_cycle", cyc, f_b.cyc);
                chk("b_taddr", int'(taddr_b), int'(f_b.addr));
                exp_cy_b = f_b.cy;
            end
            last_tren_b = cyc;
        end
        if (creaden_b) begin
            chk("b_creaden_lag", cyc, last_tren_b + 1);
            chk("b_cy", int'(cy_b), int'(exp_cy_b));
        end
    end

    // ---------------- stimulus ----------------
    // Called #1 after an edge; linestart is sampled at the next edge.
    task automatic line_a_go(input logic [7:0] ln, input int npix, input bit fin,
                             input int nfetch, input logic [15:0] pix, output int base);
        ls_a   = 1'b1;
        line_a = ln;
        base   = cyc;
        for (int k = 0; k < npix; k++)
            evq_a.push_back('{base + 5 + k, {1'b0, pix[15-k]}});
        if (fin)
            evq_a.push_back('{base + 21, 2'd2});
        for (int f = 0; f < nfetch; f++)
            fq_a.push_back('{base + 1 + 8 * f, {ln[7:3], 7'(f)}, ln[2:0]});
        @(posedge clk); #1;
        ls_a   = 1'b0;
        line_a = ~ln;
    endtask

    task automatic line_b_go(input logic [7:0] ln, output int base);
        ls_b   = 1'b1;
        line_b = ln;
        base   = cyc;
        for (int k = 0; k < 12; k++)
            evq_b.push_back('{base + 5 + k, 2'd1});
        evq_b.push_back('{base + 17, 2'd2});
        for (int f = 0; f < 3; f++)
            fq_b.push_back('{base + 1 + 4 * f, {ln[7:3], 7'(f)}, ln[2:0]});
        @(posedge clk); #1;
        ls_b   = 1'b0;
        line_b = ~ln;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    int b0;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            chk("idle_pixvalid", int'(pixvalid_a | pixvalid_b), 0);
            chk("idle_tren", int'(tren_a | tren_b), 0);
            chk("idle_creaden", int'(creaden_a | creaden_b), 0);
            chk("idle_busy", int'(busy_a | busy_b), 0);
            chk("idle_lineend", int'(lineend_a | lineend_b), 0);
            @(posedge clk); #1;
        end

        // Basic line, then a new linestart coincident with its lineend.
        line_a_go(8'h0B, 16, 1'b1, 2, 16'hA53C, b0);
        chk("busy_after_linestart", int'(busy_a), 1);
        idle_cycles(20);
        line_a_go(8'h0B, 16, 1'b1, 2, 16'hA53C, b0);
        idle_cycles(25);

        line_b_go(8'h0B, b0);
        idle_cycles(22);

        // Abort during pixel 6 (cycle base+11).
        line_a_go(8'h0B, 7, 1'b0, 2, 16'hA53C, b0);
        idle_cycles(10);
        line_a_go(8'h12, 16, 1'b1, 2, 16'hA53C, b0);
        idle_cycles(25);

        // Reset during pixel 3 of a line.
        line_a_go(8'h0B, 4, 1'b0, 1, 16'hA53C, b0);
        idle_cycles(7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_pixvalid", int'(pixvalid_a), 0);
        chk("rst_pixel", int'(pixel_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_tren", int'(tren_a), 0);
        chk("rst_creaden", int'(creaden_a), 0);
        chk("rst_lineend", int'(lineend_a), 0);
        chk("rst_taddr", int'(taddr_a), 0);
        chk("rst_cy", int'(cy_a), 0);
        idle_cycles(3);
        line_a_go(8'h0B, 16, 1'b1, 2, 16'hA53C, b0);
        idle_cycles(25);

`ifdef TEXT_CURSOR_EN
        curon  = 1'b1;
        currow = 5'd1;
        curcol = 7'd0;
        line_a_go(8'h08, 16, 1'b1, 2, 16'h5A3C, b0);
        idle_cycles(25);
        curon = 1'b0;
        line_a_go(8'h08, 16, 1'b1, 2, 16'hA53C, b0);
        idle_cycles(25);
`endif

        chk("a_events_drained", evq_a.size(), 0);
        chk("a_fetches_drained", fq_a.size(), 0);
        chk("b_events_drained", evq_b.size(), 0);
        chk("b_fetches_drained", fq_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
